// File: rtl/demux12_pkg.sv
// Shared definitions for the demux12 stream splitter.
// Optional pop counters are enabled with DEMUX12_COUNT_EN.
package demux12_pkg;

    localparam int DATA_W_DEF = 4;
    localparam int DEPTH_MAX  = 8;

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/demux12_fifo2.sv
// DEPTH-entry synchronous FIFO with registered storage and pointers.
// Reset clears storage so the head reads 0 while empty after reset.
module demux12_fifo2
    import demux12_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty
);

    localparam int PW = clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count;
    logic              push;
    logic              pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push    = wr_en & ~full;
    assign pop     = rd_en & ~empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            // simultaneous push and pop leaves occupancy unchanged
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/demux12_stream.sv
// 1-to-2 stream demux: steers each beat by in_sel into a per-output FIFO.
// Define DEMUX12_COUNT_EN to add the 8-bit cnt0/cnt1 pop counters.
module demux12_stream
    import demux12_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              out1_valid,
    input  logic              out1_ready
`ifdef DEMUX12_COUNT_EN
    ,
    output logic [7:0]        cnt0,
    output logic [7:0]        cnt1
`endif
);

    logic full0, full1;
    logic empty0, empty1;
    logic push0, push1;
    logic pop0, pop1;

    // a full target stalls the input even if the other FIFO has room
    assign in_ready = (in_sel == SEL_OUT1) ? ~full1 : ~full0;

    assign push0 = in_valid & in_ready & (in_sel == SEL_OUT0);
    assign push1 = in_valid & in_ready & (in_sel == SEL_OUT1);

    assign out0_valid = ~empty0;
    assign out1_valid = ~empty1;
    assign pop0 = out0_valid & out0_ready;
    assign pop1 = out1_valid & out1_ready;

    demux12_fifo2 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push0),
        .wr_data (in_data),
        .rd_en   (pop0),
        .rd_data (out0_data),
        .full    (full0),
        .empty   (empty0)
    );

    demux12_fifo2 #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push1),
        .wr_data (in_data),
        .rd_en   (pop1),
        .rd_data (out1_data),
        .full    (full1),
        .empty   (empty1)
    );

`ifdef DEMUX12_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (pop0) cnt0 <= cnt0 + 8'd1;
            if (pop1) cnt1 <= cnt1 + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux12_stream.sv
// Bench for demux12_stream: directed table, queue-model random run, async reset.
// Counter checks are compiled in when DEMUX12_COUNT_EN is defined.
module tb_demux12_stream;

    localparam int DEPTH = 2;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] out0_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [3:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
`ifdef DEMUX12_COUNT_EN
    logic [7:0] cnt0;
    logic [7:0] cnt1;
`endif

    demux12_stream #(.DATA_W(4), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
`ifdef DEMUX12_COUNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // reference model: one queue per output plus delivered-beat totals
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    int m_cnt0 = 0;
    int m_cnt1 = 0;

    typedef struct {
        logic       v;
        logic       s;
        logic [3:0] d;
        logic       r0;
        logic       r1;
        logic       rdy;
        logic       v0;
        logic [3:0] d0;
        logic       v1;
        logic [3:0] d1;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_ready(input logic s);
        return s ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    endfunction

    // drive inputs (just after negedge), then check outputs against the model
    task automatic drive(input logic v, input logic s, input logic [3:0] d,
                         input logic r0, input logic r1);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        #1;
        chk("m_in_ready", {7'd0, in_ready}, {7'd0, exp_ready(s)});
        chk("m_out0_valid", {7'd0, out0_valid}, {7'd0, q0.size() > 0});
        chk("m_out1_valid", {7'd0, out1_valid}, {7'd0, q1.size() > 0});
        if (q0.size() > 0) chk("m_out0_data", {4'd0, out0_data}, {4'd0, q0[0]});
        if (q1.size() > 0) chk("m_out1_data", {4'd0, out1_data}, {4'd0, q1[0]});
`ifdef DEMUX12_COUNT_EN
        chk("m_cnt0", cnt0, 8'(m_cnt0));
        chk("m_cnt1", cnt1, 8'(m_cnt1));
`endif
    endtask

    // apply the rising edge to the model and the DUT
    task automatic advance();
        logic acc;
        acc = in_valid && exp_ready(in_sel);
        if (out0_ready && q0.size() > 0) begin
            void'(q0.pop_front());
            m_cnt0 = (m_cnt0 + 1) % 256;
        end
        if (out1_ready && q1.size() > 0) begin
            void'(q1.pop_front());
            m_cnt1 = (m_cnt1 + 1) % 256;
        end
        if (acc) begin
            if (in_sel) q1.push_back(in_data);
            else        q0.push_back(in_data);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic v, input logic s, input logic [3:0] d,
                        input logic r0, input logic r1);
        drive(v, s, d, r0, r1);
        advance();
    endtask

    task automatic model_clear();
        q0.delete();
        q1.delete();
        m_cnt0 = 0;
        m_cnt1 = 0;
    endtask

    // asynchronous reset asserted between clock edges
    task automatic mid_reset();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", {7'd0, in_ready}, 8'd1);
        chk("rst_out0_valid", {7'd0, out0_valid}, 8'd0);
        chk("rst_out1_valid", {7'd0, out1_valid}, 8'd0);
        chk("rst_out0_data", {4'd0, out0_data}, 8'd0);
        chk("rst_out1_data", {4'd0, out1_data}, 8'd0);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic       v, s, r0, r1;
        logic [3:0] d;
        logic       stalled;

        tbl[0]  = '{1'b1, 1'b0, 4'hA, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0};
        tbl[1]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 4'h0};
        tbl[2]  = '{1'b1, 1'b0, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0};
        tbl[3]  = '{1'b1, 1'b0, 4'h2, 1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 1'b0, 4'h0};
        tbl[4]  = '{1'b1, 1'b0, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 1'b0, 4'h0};
        tbl[5]  = '{1'b1, 1'b1, 4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 1'b0, 4'h0};
        tbl[6]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 1'b1, 4'h5};
        tbl[7]  = '{1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 4'h2, 1'b1, 4'h5};
        tbl[8]  = '{1'b1, 1'b0, 4'h7, 1'b1, 1'b1, 1'b1, 1'b1, 4'h2, 1'b0, 4'h0};
        tbl[9]  = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h7, 1'b0, 4'h0};
        tbl[10] = '{1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0};

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        in_data    = 4'h0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", {7'd0, in_ready}, 8'd1);
        chk("reset_out0_valid", {7'd0, out0_valid}, 8'd0);
        chk("reset_out1_valid", {7'd0, out1_valid}, 8'd0);
        chk("reset_out0_data", {4'd0, out0_data}, 8'd0);
        chk("reset_out1_data", {4'd0, out1_data}, 8'd0);
        rst_n = 1'b1;

        // directed table, starting at the first edge after reset release
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r0, tbl[i].r1);
            chk($sformatf("tbl%0d_in_ready", i), {7'd0, in_ready}, {7'd0, tbl[i].rdy});
            chk($sformatf("tbl%0d_out0_valid", i), {7'd0, out0_valid}, {7'd0, tbl[i].v0});
            chk($sformatf("tbl%0d_out1_valid", i), {7'd0, out1_valid}, {7'd0, tbl[i].v1});
            if (tbl[i].v0)
                chk($sformatf("tbl%0d_out0_data", i), {4'd0, out0_data}, {4'd0, tbl[i].d0});
            if (tbl[i].v1)
                chk($sformatf("tbl%0d_out1_data", i), {4'd0, out1_data}, {4'd0, tbl[i].d1});
            advance();
        end

        // random traffic; select alternates for the first 16 beats
        stalled = 1'b0;
        v = 1'b0;
        s = 1'b0;
        d = 4'h0;
        for (int i = 0; i < 300; i++) begin
            if (!stalled) begin
                v = ($urandom_range(0, 3) != 0);
                s = (i < 16) ? 1'(i) : 1'($urandom);
                d = 4'($urandom);
            end
            r0 = ($urandom_range(0, 2) != 0);
            r1 = ($urandom_range(0, 2) != 0);
            stalled = v && !exp_ready(s);
            step(v, s, d, r0, r1);
        end

        // load both FIFOs, then reset between edges
        step(1'b1, 1'b0, 4'h9, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'hC, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4'hD, 1'b0, 1'b0);
        mid_reset();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);

`ifdef DEMUX12_COUNT_EN
        mid_reset();
        for (int i = 0; i < 257; i++) step(1'b1, 1'b1, 4'(i), 1'b1, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        chk("cnt1_wrap", cnt1, 8'd1);
        chk("cnt0_idle", cnt0, 8'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
